wb_commit_arbiter: RTL and testbench

- Shares one register-file commit port among NUM_UNITS execution units.
- Each unit presents a writeback result (done, id, phys_addr, data) and holds it until acknowledged.
- The arbiter grants one unit per cycle using round-robin priority, then drives a registered commit packet to the register file and the ID/retire tracking logic.
- Sits between the unit writeback interfaces and the commit path; honours the global-control writeback suppress.

---
 rtl/wb_commit_arbiter.sv | 83 ++++++++
 tb/tb_wb_commit_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_arbiter.sv
// Round-robin arbiter that shares one register-file commit port among NUM_UNITS
// writeback units; grants are combinational, the commit packet is registered.
module wb_commit_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int ID_W      = 3,
  parameter int PHYS_W    = 6,
  parameter int DATA_W    = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_UNITS-1:0]           unit_done,
  input  logic [NUM_UNITS*ID_W-1:0]      unit_id,
  input  logic [NUM_UNITS*PHYS_W-1:0]    unit_phys_addr,
  input  logic [NUM_UNITS*DATA_W-1:0]    unit_data,
  output logic [NUM_UNITS-1:0]           unit_ack,
  input  logic                           writeback_supress,
  output logic                           commit_valid,
  output logic [ID_W-1:0]                commit_id,
  output logic [PHYS_W-1:0]              commit_phys_addr,
  output logic [DATA_W-1:0]              commit_data,
  output logic [$clog2(NUM_UNITS)-1:0]   grant_idx
);

  localparam int IDX_W = $clog2(NUM_UNITS);

  // Handshake: unit i holds done/id/phys_addr/data stable while unit_done[i]=1
  // and unit_ack[i]=0; the result is transferred in the cycle unit_ack[i]=1.

  logic [IDX_W-1:0] ptr;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_sel;
  logic [IDX_W-1:0] ptr_next;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_UNITS) sum = sum - NUM_UNITS;
    return IDX_W'(sum);
  endfunction

  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (!grant_valid && unit_done[wrap_add(ptr, k)]) begin
        grant_valid = 1'b1;
        grant_sel   = wrap_add(ptr, k);
      end
    end
    // Suppress and reset both veto the grant, so the unit keeps holding its result.
    if (writeback_supress || !rst_n) grant_valid = 1'b0;
  end

  always_comb begin
    unit_ack = '0;
    if (grant_valid) unit_ack[grant_sel] = 1'b1;
  end

  assign ptr_next = (grant_sel == IDX_W'(NUM_UNITS - 1)) ? '0 : grant_sel + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr              <= '0;
      commit_valid     <= 1'b0;
      commit_id        <= '0;
      commit_phys_addr <= '0;
      commit_data      <= '0;
      grant_idx        <= '0;
    end else begin
      commit_valid <= grant_valid;
      if (grant_valid) begin
        ptr              <= ptr_next;
        grant_idx        <= grant_sel;
        commit_id        <= unit_id[grant_sel*ID_W +: ID_W];
        commit_phys_addr <= unit_phys_addr[grant_sel*PHYS_W +: PHYS_W];
        commit_data      <= unit_data[grant_sel*DATA_W +: DATA_W];
      end
    end
  end

  ack_onehot0_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(unit_ack));

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Directed bench for wb_commit_arbiter: a queue-free round-robin model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_wb_commit_arbiter;
  localparam int N      = 4;
  localparam int ID_W   = 3;
  localparam int PHYS_W = 6;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]        b_done = '0;
  logic [ID_W-1:0]     b_id   [N];
  logic [PHYS_W-1:0]   b_phys [N];
  logic [DATA_W-1:0]   b_data [N];
  logic                sup = 1'b0;

  logic [N*ID_W-1:0]   unit_id;
  logic [N*PHYS_W-1:0] unit_phys_addr;
  logic [N*DATA_W-1:0] unit_data;
  logic [N-1:0]        unit_ack;
  logic                commit_valid;
  logic [ID_W-1:0]     commit_id;
  logic [PHYS_W-1:0]   commit_phys_addr;
  logic [DATA_W-1:0]   commit_data;
  logic [IDX_W-1:0]    grant_idx;

  always_comb begin
    unit_id = '0;
    unit_phys_addr = '0;
    unit_data = '0;
    for (int i = 0; i < N; i++) begin
      unit_id[i*ID_W +: ID_W]         = b_id[i];
      unit_phys_addr[i*PHYS_W +: PHYS_W] = b_phys[i];
      unit_data[i*DATA_W +: DATA_W]   = b_data[i];
    end
  end

  wb_commit_arbiter #(.NUM_UNITS(N), .ID_W(ID_W), .PHYS_W(PHYS_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .unit_done(b_done), .unit_id(unit_id),
    .unit_phys_addr(unit_phys_addr), .unit_data(unit_data), .unit_ack(unit_ack),
    .writeback_supress(sup), .commit_valid(commit_valid), .commit_id(commit_id),
    .commit_phys_addr(commit_phys_addr), .commit_data(commit_data), .grant_idx(grant_idx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: a rotating priority pointer and the last committed packet
  int                m_ptr = 0;
  logic              m_valid = 1'b0;
  logic [ID_W-1:0]   m_id = '0;
  logic [PHYS_W-1:0] m_phys = '0;
  logic [DATA_W-1:0] m_data = '0;
  int                m_gidx = 0;

  function automatic int model_winner();
    if (sup) return -1;
    for (int k = 0; k < N; k++)
      if (b_done[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_valid <= 1'b0; m_id <= '0; m_phys <= '0; m_data <= '0; m_gidx <= 0;
    end else begin
      int w;
      w = model_winner();
      m_valid <= (w >= 0);
      if (w >= 0) begin
        m_ptr  <= (w + 1) % N;
        m_gidx <= w;
        m_id   <= b_id[w];
        m_phys <= b_phys[w];
        m_data <= b_data[w];
      end
    end
  end

  // scoreboard compare on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      int w;
      logic [N-1:0] exp_ack;
      w = model_winner();
      exp_ack = '0;
      if (w >= 0) exp_ack[w] = 1'b1;
      check("model_ack", 64'(unit_ack), 64'(exp_ack));
      check("model_valid", 64'(commit_valid), 64'(m_valid));
      check("model_gidx", 64'(grant_idx), 64'(m_gidx));
      check("model_ptr", 64'(dut.ptr), 64'(m_ptr));
      if (m_valid) begin
        check("model_id", 64'(commit_id), 64'(m_id));
        check("model_phys", 64'(commit_phys_addr), 64'(m_phys));
        check("model_data", 64'(commit_data), 64'(m_data));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int i, input logic [ID_W-1:0] id,
                          input logic [PHYS_W-1:0] ph, input logic [DATA_W-1:0] d);
    b_id[i] = id; b_phys[i] = ph; b_data[i] = d; b_done[i] = 1'b1;
  endtask

  task automatic clr_unit(input int i);
    b_done[i] = 1'b0;
  endtask

  logic [N-1:0] rr_ack [6];

  initial begin
    for (int i = 0; i < N; i++) begin
      b_id[i] = '0; b_phys[i] = '0; b_data[i] = '0;
    end
    rr_ack[0] = 4'b0001; rr_ack[1] = 4'b0010; rr_ack[2] = 4'b0100;
    rr_ack[3] = 4'b1000; rr_ack[4] = 4'b0001; rr_ack[5] = 4'b0010;

    // reset state
    #2;
    check("rst_valid", 64'(commit_valid), 64'd0);
    check("rst_ack", 64'(unit_ack), 64'd0);
    check("rst_gidx", 64'(grant_idx), 64'd0);
    check("rst_data", 64'(commit_data), 64'd0);
    check("rst_ptr", 64'(dut.ptr), 64'd0);
    #10 rst_n = 1'b1;
    tick();

    // single request from unit 2
    set_unit(2, 3'd5, 6'h21, 32'hDEADBEEF);
    #2 check("single_ack", 64'(unit_ack), 64'b0100);
    tick();
    clr_unit(2);
    check("single_valid", 64'(commit_valid), 64'd1);
    check("single_id", 64'(commit_id), 64'd5);
    check("single_phys", 64'(commit_phys_addr), 64'h21);
    check("single_data", 64'(commit_data), 64'hDEADBEEF);
    check("single_gidx", 64'(grant_idx), 64'd2);
    check("single_ptr", 64'(dut.ptr), 64'd3);

    // wrap and priority: ptr=3 with units 1 and 3 requesting
    set_unit(1, 3'd1, 6'h11, 32'h1111_0001);
    set_unit(3, 3'd3, 6'h33, 32'h3333_0003);
    #2 check("wrap_ack3", 64'(unit_ack), 64'b1000);
    tick();
    clr_unit(3);
    check("wrap_ptr0", 64'(dut.ptr), 64'd0);
    #1 check("wrap_ack1", 64'(unit_ack), 64'b0010);
    tick();
    clr_unit(1);
    check("wrap_gidx1", 64'(grant_idx), 64'd1);
    check("wrap_data1", 64'(commit_data), 64'h1111_0001);

    // round robin with all units requesting from a fresh reset
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_unit(i, 3'(i), 6'(8 + i), 32'hA000_0000 + 32'(i));
    #2 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1 check("rr_ack", 64'(unit_ack), 64'(rr_ack[c]));
      tick();
      set_unit(c % N, 3'(c + 4), 6'(c + 40), 32'hB000_0000 + 32'(c));
      check("rr_valid", 64'(commit_valid), 64'd1);
      check("rr_gidx", 64'(grant_idx), 64'(c % N));
    end

    // async reset mid-stream, then units 2 and 0 re-arbitrated from ptr=0
    clr_unit(1);
    clr_unit(3);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(commit_valid), 64'd0);
    check("arst_ack", 64'(unit_ack), 64'd0);
    check("arst_ptr", 64'(dut.ptr), 64'd0);
    #1 rst_n = 1'b1;
    #1 check("arst_ack0", 64'(unit_ack), 64'b0001);
    tick();
    clr_unit(0);
    #1 check("arst_ack2", 64'(unit_ack), 64'b0100);
    tick();
    clr_unit(2);

    // suppress kills the packet that would follow and holds off unit 1
    set_unit(0, 3'd6, 6'h30, 32'hC0DE_0000);
    #2 check("sup_ack0", 64'(unit_ack), 64'b0001);
    tick();
    clr_unit(0);
    set_unit(1, 3'd7, 6'h31, 32'hC0DE_0001);
    sup = 1'b1;
    #2;
    check("sup_ack_none", 64'(unit_ack), 64'd0);
    check("sup_valid_t1", 64'(commit_valid), 64'd1);
    check("sup_gidx_t1", 64'(grant_idx), 64'd0);
    tick();
    sup = 1'b0;
    #2;
    check("sup_valid_t2", 64'(commit_valid), 64'd0);
    check("sup_ack1", 64'(unit_ack), 64'b0010);
    check("sup_ptr_hold", 64'(dut.ptr), 64'd1);
    tick();
    clr_unit(1);
    check("sup_valid_t3", 64'(commit_valid), 64'd1);
    check("sup_data_t3", 64'(commit_data), 64'hC0DE_0001);
    tick();

    // idle: nothing requested for 10 cycles
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_ack", 64'(unit_ack), 64'd0);
      check("idle_valid", 64'(commit_valid), 64'd0);
    end
    check("idle_ptr", 64'(dut.ptr), 64'd2);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
